// File: rtl/riscv_mc_ctrl_if.sv
// Controller-to-datapath bundle for the multi-cycle RV32I control unit.
// `halted` is present only when ILLEGAL_HALT_EN is defined.
interface riscv_mc_ctrl_if #(
    parameter int ST_W = 4
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            zero;
    logic            PC_Write;
    logic [1:0]      PC_s;
    logic            IR_Write;
    logic            Reg_Write;
    logic            Mem_Write;
    logic            rs2_imm_s;
    logic [2:0]      imm_s;
    logic [1:0]      w_data_s;
    logic [3:0]      ALU_OP;
    logic [ST_W-1:0] state;
    logic            retire;
`ifdef ILLEGAL_HALT_EN
    logic            halted;
`endif

    modport slave (
        input  opcode, funct3, funct7b5, zero,
        output PC_Write, PC_s, IR_Write, Reg_Write, Mem_Write, rs2_imm_s,
               imm_s, w_data_s, ALU_OP, state, retire
`ifdef ILLEGAL_HALT_EN
             , halted
`endif
    );

    modport master (
        output opcode, funct3, funct7b5, zero,
        input  PC_Write, PC_s, IR_Write, Reg_Write, Mem_Write, rs2_imm_s,
               imm_s, w_data_s, ALU_OP, state, retire
`ifdef ILLEGAL_HALT_EN
             , halted
`endif
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back.
// Optional ILLEGAL_HALT_EN: unknown opcodes park the FSM in HALT and set `halted`.
module riscv_mc_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    riscv_mc_ctrl_if.slave  bus
);
    typedef enum logic [ST_W-1:0] {
        S_IDLE = 0,
        S_IF   = 1,
        S_ID   = 2,
        S_EXR  = 3,
        S_EXI  = 4,
        S_WBA  = 5,
        S_LUI  = 6,
        S_MA   = 7,
        S_MR   = 8,
        S_WBM  = 9,
        S_MW   = 10,
        S_BR   = 11,
        S_JAL  = 12,
        S_JALR = 13
`ifdef ILLEGAL_HALT_EN
      , S_HALT = 14
`endif
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_retire;
    logic [1:0] w_pc_s;
    logic       w_rs2_imm_s;
    logic [2:0] w_imm_s;
    logic [1:0] w_w_data_s;
    logic [3:0] w_alu_op;
    logic [3:0] w_alu_r;
    logic [3:0] w_alu_i;
    logic       w_op_b5;

    assign w_alu_r = {bus.funct7b5, bus.funct3};
    assign w_alu_i = {bus.funct7b5 & (bus.funct3 == 3'b101), bus.funct3};
    // IR is stable after fetch, so opcode bit 5 tells R from I-imm and SW from LW
    // in the later states without extra state bits.
    assign w_op_b5 = bus.opcode[5];

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_retire    = 1'b0;
        w_pc_s      = 2'b00;
        w_rs2_imm_s = 1'b0;
        w_imm_s     = 3'b000;
        w_w_data_s  = 2'b00;
        w_alu_op    = 4'b0000;
        case (r_state)
            S_IDLE: w_next = S_IF;
            S_IF: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_ID;
            end
            S_ID: begin
                case (bus.opcode)
                    OP_R:    w_next = S_EXR;
                    OP_IMM:  w_next = S_EXI;
                    OP_LUI:  w_next = S_LUI;
                    OP_LOAD: w_next = S_MA;
                    OP_STOR: w_next = S_MA;
                    OP_BR:   w_next = S_BR;
                    OP_JAL:  w_next = S_JAL;
                    OP_JALR: w_next = S_JALR;
`ifdef ILLEGAL_HALT_EN
                    default: w_next = S_HALT;
`else
                    default: w_next = S_IF;
`endif
                endcase
            end
            S_EXR: begin
                w_alu_op = w_alu_r;
                w_next   = S_WBA;
            end
            S_EXI: begin
                w_rs2_imm_s = 1'b1;
                w_alu_op    = w_alu_i;
                w_next      = S_WBA;
            end
            S_WBA: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_rs2_imm_s = ~w_op_b5;
                w_alu_op    = w_op_b5 ? w_alu_r : w_alu_i;
                w_next      = S_IF;
            end
            S_LUI: begin
                w_reg_write = 1'b1;
                w_w_data_s  = 2'b01;
                w_imm_s     = 3'b011;
                w_retire    = 1'b1;
                w_next      = S_IF;
            end
            S_MA: begin
                w_rs2_imm_s = 1'b1;
                w_imm_s     = {2'b00, w_op_b5};
                w_next      = w_op_b5 ? S_MW : S_MR;
            end
            S_MR: begin
                w_rs2_imm_s = 1'b1;
                w_next      = S_WBM;
            end
            S_WBM: begin
                w_reg_write = 1'b1;
                w_w_data_s  = 2'b10;
                w_retire    = 1'b1;
                w_next      = S_IF;
            end
            S_MW: begin
                w_mem_write = 1'b1;
                w_rs2_imm_s = 1'b1;
                w_imm_s     = 3'b001;
                w_retire    = 1'b1;
                w_next      = S_IF;
            end
            S_BR: begin
                w_alu_op   = 4'b1000;
                w_imm_s    = 3'b010;
                w_pc_s     = 2'b10;
                w_pc_write = bus.zero;
                w_retire   = 1'b1;
                w_next     = S_IF;
            end
            S_JAL: begin
                w_reg_write = 1'b1;
                w_w_data_s  = 2'b11;
                w_pc_write  = 1'b1;
                w_pc_s      = 2'b10;
                w_imm_s     = 3'b100;
                w_retire    = 1'b1;
                w_next      = S_IF;
            end
            S_JALR: begin
                w_reg_write = 1'b1;
                w_w_data_s  = 2'b11;
                w_pc_write  = 1'b1;
                w_pc_s      = 2'b01;
                w_rs2_imm_s = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_IF;
            end
`ifdef ILLEGAL_HALT_EN
            S_HALT: w_next = S_HALT;
`endif
            default: w_next = S_IDLE;
        endcase
    end

`ifdef ILLEGAL_HALT_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (!rst_n)                r_halted <= 1'b0;
        else if (w_next == S_HALT) r_halted <= 1'b1;
    end

    assign bus.halted = r_halted;
`endif

    // Reset masks every write strobe so an interrupted instruction never commits.
    assign bus.PC_Write  = w_pc_write  & rst_n;
    assign bus.IR_Write  = w_ir_write  & rst_n;
    assign bus.Reg_Write = w_reg_write & rst_n;
    assign bus.Mem_Write = w_mem_write & rst_n;
    assign bus.retire    = w_retire    & rst_n;
    assign bus.PC_s      = w_pc_s;
    assign bus.rs2_imm_s = w_rs2_imm_s;
    assign bus.imm_s     = w_imm_s;
    assign bus.w_data_s  = w_w_data_s;
    assign bus.ALU_OP    = w_alu_op;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: directed instructions plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_riscv_mc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_mc_ctrl_if #(.ST_W(4)) bus();
    riscv_mc_ctrl #(.ST_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef enum int {C_R, C_I, C_LUI, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_ILL} cls_t;

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0110111: return C_LUI;
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [6:0] opcode_of(input cls_t c);
        case (c)
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_LUI:   return 7'b0110111;
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            default: return 7'b1100111;
        endcase
    endfunction

    // Clock edges from IF to the next IF for each instruction class.
    function automatic int plen(input cls_t c);
        case (c)
            C_R, C_I, C_SW: return 4;
            C_LW:           return 5;
            C_ILL:          return 2;
            default:        return 3;
        endcase
    endfunction

    // Documented state number visited at step idx of an instruction (0 = IF).
    function automatic int path_of(input cls_t c, input int idx);
        if (idx == 0) return 1;
        if (idx == 1) return 2;
        case (c)
            C_R:     return (idx == 2) ? 3 : 5;
            C_I:     return (idx == 2) ? 4 : 5;
            C_LUI:   return 6;
            C_LW:    return (idx == 2) ? 7 : (idx == 3) ? 8 : 9;
            C_SW:    return (idx == 2) ? 7 : 10;
            C_BR:    return 11;
            C_JAL:   return 12;
            C_JALR:  return 13;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input cls_t c, input logic [2:0] f3, input logic f7);
        case (c)
            C_R:     return {f7, f3};
            C_I:     return {f7 && (f3 == 3'd5), f3};
            C_BR:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic exp_rs2(input cls_t c);
        return !(c == C_R || c == C_BR);
    endfunction

    function automatic logic [2:0] exp_imm(input cls_t c);
        case (c)
            C_SW:    return 3'd1;
            C_BR:    return 3'd2;
            C_LUI:   return 3'd3;
            C_JAL:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_wd(input cls_t c);
        case (c)
            C_LUI:        return 2'd1;
            C_LW:         return 2'd2;
            C_JAL, C_JALR: return 2'd3;
            default:      return 2'd0;
        endcase
    endfunction

    // Runs one instruction starting in IF (called #1 after a rising edge).
    task automatic run_instr(input logic [31:0] w, input logic z);
        cls_t c;
        int n;
        logic last, pcw, irw, rw, mw, ret, chk_sel;
        logic [4:0] exp_en, got_en;
        logic [1:0] exp_pcs;
        c = classify(w[6:0]);
        n = plen(c);
        bus.opcode = w[6:0];
        bus.funct3 = w[14:12];
        bus.funct7b5 = w[30];
        bus.zero = z;
        #1;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            pcw = (i == 0) || (last && (c == C_JAL || c == C_JALR)) || (last && c == C_BR && z);
            irw = (i == 0);
            rw  = last && (c inside {C_R, C_I, C_LUI, C_LW, C_JAL, C_JALR});
            mw  = last && (c == C_SW);
            ret = last && (c != C_ILL);
            exp_en = {pcw, irw, rw, mw, ret};
            got_en = {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire};
            n_tests++;
            if (bus.state !== 4'(path_of(c, i))) begin
                n_fail++;
                $display("FAIL state w=%h step %0d: got %0d want %0d", w, i, bus.state, path_of(c, i));
            end
            n_tests++;
            if (got_en !== exp_en) begin
                n_fail++;
                $display("FAIL enables w=%h step %0d: got %b want %b (pcw,irw,rw,mw,ret)", w, i, got_en, exp_en);
            end
            if (rw) begin
                n_tests++;
                if (bus.w_data_s !== exp_wd(c)) begin
                    n_fail++;
                    $display("FAIL w_data_s w=%h step %0d: got %b want %b", w, i, bus.w_data_s, exp_wd(c));
                end
            end
            if (pcw || (last && c == C_BR)) begin
                exp_pcs = (i == 0) ? 2'd0 : (c == C_JALR) ? 2'd1 : 2'd2;
                n_tests++;
                if (bus.PC_s !== exp_pcs) begin
                    n_fail++;
                    $display("FAIL PC_s w=%h step %0d: got %b want %b", w, i, bus.PC_s, exp_pcs);
                end
            end
            chk_sel = (i >= 2) && (c != C_ILL) && !(c == C_LW && i == 4);
            if (chk_sel && c != C_LUI && c != C_JAL) begin
                n_tests++;
                if ({bus.ALU_OP, bus.rs2_imm_s} !== {exp_alu(c, w[14:12], w[30]), exp_rs2(c)}) begin
                    n_fail++;
                    $display("FAIL alu_sel w=%h step %0d: got %b/%b want %b/%b", w, i,
                             bus.ALU_OP, bus.rs2_imm_s, exp_alu(c, w[14:12], w[30]), exp_rs2(c));
                end
            end
            if (chk_sel && c != C_R) begin
                n_tests++;
                if (bus.imm_s !== exp_imm(c)) begin
                    n_fail++;
                    $display("FAIL imm_s w=%h step %0d: got %b want %b", w, i, bus.imm_s, exp_imm(c));
                end
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.state !== 4'd1) begin
            n_fail++;
            $display("FAIL edges w=%h: state after %0d edges is %0d, want 1", w, n, bus.state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.opcode = 7'b0110011; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.state !== 4'd0 || {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset: state %0d enables %b, want 0 / 00000", bus.state,
                     {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire});
        end
`ifdef ILLEGAL_HALT_EN
        n_tests++;
        if (bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_halted: got %b want 0", bus.halted);
        end
`endif
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (bus.state !== 4'd0 || {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle: state %0d enables %b, want 0 / 00000", bus.state,
                     {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_instr(32'h00500093, 1'b0);
        run_instr(32'h402081B3, 1'b1);
        run_instr(32'h0000A103, 1'b0);
        run_instr(32'h0020A223, 1'b0);
        run_instr(32'h00000463, 1'b1);
        run_instr(32'h00000463, 1'b0);
        run_instr(32'h008000EF, 1'b0);
        run_instr(32'h000080E7, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] w;
        cls_t c;
        for (int k = 0; k < 200; k++) begin
            c = cls_t'($urandom_range(7, 0));
            w = $urandom;
            w[6:0] = opcode_of(c);
            run_instr(w, 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] got_en;
        // LW interrupted in MR
        bus.opcode = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.state !== 4'd8) begin
            n_fail++;
            $display("FAIL mid_lw_state: got %0d want 8", bus.state);
        end
        rst_n = 1'b0;
        #1;
        got_en = {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire};
        n_tests++;
        if (got_en !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_lw_enables: got %b want 00000", got_en);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.state !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_lw_reset_state: got %0d want 0", bus.state);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        // JAL interrupted in its write state, where enables are otherwise high
        bus.opcode = 7'b1101111;
        repeat (2) @(posedge clk);
        #1;
        got_en = {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire};
        n_tests++;
        if (bus.state !== 4'd12 || got_en !== 5'b10101) begin
            n_fail++;
            $display("FAIL mid_jal_pre: state %0d enables %b, want 12 / 10101", bus.state, got_en);
        end
        rst_n = 1'b0;
        #1;
        got_en = {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire};
        n_tests++;
        if (got_en !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_jal_enables: got %b want 00000", got_en);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.state !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_jal_reset_state: got %0d want 0", bus.state);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        w = 32'h0000007F;
`ifdef ILLEGAL_HALT_EN
        bus.opcode = w[6:0]; bus.funct3 = w[14:12]; bus.funct7b5 = w[30]; bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (bus.state !== 4'd14 || bus.halted !== 1'b1 ||
                {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire} !== 5'b0) begin
                n_fail++;
                $display("FAIL halt cycle %0d: state %0d halted %b enables %b, want 14 / 1 / 00000", k,
                         bus.state, bus.halted, {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write, bus.retire});
            end
            bus.opcode = 7'b0110011;
            @(posedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.state !== 4'd0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_clear: state %0d halted %b, want 0 / 0", bus.state, bus.halted);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_instr(32'h00500093, 1'b0);
`else
        run_instr(w, 1'b0);
        for (int k = 0; k < 10; k++) begin
            w = $urandom;
            while (classify(w[6:0]) != C_ILL) w[6:0] = 7'($urandom);
            run_instr(w, 1'($urandom_range(1, 0)));
        end
        run_instr(32'h00500093, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle control unit for the RV32I subset CPU: ADD/SUB/logic R-type, ADDI/ORI/XORI-class I-type, LUI, LW, SW, BEQ, JAL, JALR. It is a state machine that sequences fetch, decode, execute, memory and write-back over several clock edges. It drives every write enable and mux select of the existing datapath: PC, IR, register file, ALU, immediate unit and data memory. It sits beside the datapath inside `cpu`, so each board `clk` press advances exactly one controller state.

## Interface
Parameters:
- `ST_W`, default 4: state register width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `opcode`, in, 7: IR[6:0].
- `funct3`, in, 3: IR[14:12].
- `funct7b5`, in, 1: IR[30].
- `zero`, in, 1: ALU zero flag, combinational from the current ALU operands.
- `PC_Write`, out, 1: PC load enable.
- `PC_s`, out, 2: PC source. 00 = PC+4, 01 = ALU F, 10 = PC0+imm, where PC0 is the PC of the current instruction.
- `IR_Write`, out, 1: IR load enable. PC0 is captured with it.
- `Reg_Write`, out, 1: register file write enable.
- `Mem_Write`, out, 1: data memory write enable.
- `rs2_imm_s`, out, 1: ALU B operand. 0 = rs2, 1 = imm.
- `imm_s`, out, 3: immediate format. 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- `w_data_s`, out, 2: W_Data source. 00 = ALU F, 01 = imm, 10 = MDR, 11 = PC.
- `ALU_OP`, out, 4: {b3, funct3}. 0000 = ADD, 1000 = SUB.
- `state`, out, ST_W: current state, for the debug port.
- `retire`, out, 1: one-cycle pulse in the final state of each instruction.
- `halted`, out, 1: sticky illegal-opcode flag. Exists only with the macro defined.

## Operation
State encodings and transitions:
- IDLE (0): all outputs 0. Goes to IF.
- IF (1): `IR_Write`=1, `PC_Write`=1, `PC_s`=00. Goes to ID.
- ID (2): no enables. Branches on `opcode`:
  - 0110011 to EXR.
  - 0010011 to EXI.
  - 0110111 to LUI.
  - 0000011 or 0100011 to MA.
  - 1100011 to BR.
  - 1101111 to JAL.
  - 1100111 to JALR.
  - Any other opcode: see Configuration.
- EXR (3): `rs2_imm_s`=0, `ALU_OP`={funct7b5, funct3}. Goes to WBA.
- EXI (4): `rs2_imm_s`=1, `imm_s`=I. `ALU_OP`={funct7b5 & (funct3==101), funct3}. Goes to WBA.
- WBA (5): `Reg_Write`=1, `w_data_s`=00. The EX-state ALU selects are held. `retire`. Goes to IF.
- LUI (6): `Reg_Write`=1, `w_data_s`=01, `imm_s`=U. `retire`. Goes to IF.
- MA (7): `ALU_OP`=ADD, `rs2_imm_s`=1. `imm_s` is I for LW and S for SW. LW goes to MR; SW goes to MW.
- MR (8): address held; memory data is latched into MDR by the datapath. Goes to WBM.
- WBM (9): `Reg_Write`=1, `w_data_s`=10. `retire`. Goes to IF.
- MW (10): `Mem_Write`=1, address held. `retire`. Goes to IF.
- BR (11): `ALU_OP`=SUB, `rs2_imm_s`=0, `imm_s`=B, `PC_s`=10. `PC_Write`=`zero`. `retire`. Goes to IF.
- JAL (12): `Reg_Write`=1, `w_data_s`=11, `PC_Write`=1, `PC_s`=10, `imm_s`=J. `retire`. Goes to IF.
- JALR (13): `Reg_Write`=1, `w_data_s`=11, `PC_Write`=1, `PC_s`=01, `ALU_OP`=ADD, `rs2_imm_s`=1, `imm_s`=I. `retire`. Goes to IF.
  - rd receives the pre-edge PC, which is PC0+4. The PC gets rs1+imm.
- HALT (14): all enables 0. Self-loop. Exists only with the macro defined.

Additional rules:
- Outputs are Moore decoded from `state`. The only exception is `PC_Write` in BR, which also depends on `zero`.
- Unused encodings (14 without the macro, and 15) go to IDLE with all enables 0.

## Timing
- On any edge with `rst_n`=0: `state` goes to IDLE and `halted` goes to 0.
  - While `rst_n`=0, all enables (`PC_Write`, `IR_Write`, `Reg_Write`, `Mem_Write`) and `retire` are forced to 0 combinationally. This means reset in the middle of an instruction never writes.
- After reset release, the first edge enters IF and the second edge loads the first instruction.
- Edges per instruction, including IF:
  - R and I: 4.
  - LUI, BEQ, JAL, JALR: 3.
  - LW: 5.
  - SW: 4.
- `retire` is high for exactly one cycle per instruction, with no gap before the next IF.
- rd=x0 needs no special handling here; the register file ignores it.

## Configuration
- `ILLEGAL_HALT_EN` defined:
  - An unknown opcode in ID goes to HALT.
  - `halted` goes to 1 on the same edge and stays set until reset.
  - No PC or IR write occurs after that point.
- `ILLEGAL_HALT_EN` undefined:
  - An unknown opcode in ID goes directly to IF with `retire` never asserted. The instruction is treated as a NOP; the PC has already advanced by 4.
  - The `halted` port and the HALT state are absent.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093): state sequence 0,1,2,4,5,1. `Reg_Write`=1 only in state 5, with `w_data_s`=00 and `ALU_OP`=0000.
- SUB x3,x1,x2 (0x402081B3): in EXR, `ALU_OP`=1000 and `rs2_imm_s`=0. 4 edges from IF to the next IF.
- LW (0x0000A103), then SW (0x0020A223):
  - LW: states 7,8,9; `w_data_s`=10 in 9; 5 edges.
  - SW: states 7,10; `Mem_Write`=1 only in 10; `imm_s`=001 in MA.
- BEQ (0x00000463):
  - `zero`=1 gives `PC_Write`=1 and `PC_s`=10.
  - `zero`=0 gives `PC_Write`=0.
  - Both cases return to IF after 3 edges.
- JAL (0x008000EF) and JALR (0x000080E7):
  - Both: `Reg_Write`=1, `w_data_s`=11, `PC_Write`=1.
  - `PC_s` is 10 for JAL and 01 for JALR.
- Opcode 0x0000007F:
  - With the macro: state becomes 14 and `halted`=1 until `rst_n`=0.
  - Without the macro: next state is IF and `retire` never pulses.
- Reset mid-LW: `rst_n`=0 in state 8 forces all enables to 0 immediately; state is 0 on the next edge.
